proc_top_level: RTL and testbench
=================================

# proc_top_level

Top-level of the proc_v3 single-cycle 16-bit processor: program counter, 8×16 register file, ALU, 256-word instruction memory and 256-word data memory in one block. It executes one instruction per clock from instruction memory, which is loaded through a side port while reset is held. Debug outputs expose PC, register writeback and halt status for the testbench.

## Interface
- IMEM_DEPTH, 256: instruction words; PC is 8 bits.
- DMEM_DEPTH, 256: data words; data addresses use the low 8 bits.
- i_clk  in  1  clock; all state updates on its rising edge.
- i_rst_n  in  1  reset. One clock; reset is synchronous and active-high: when i_rst_n=1 at a rising edge the core resets.
- i_imem_we  in  1  instruction-memory write strobe; honoured only while i_rst_n=1.
- i_imem_addr  in  8  instruction-memory write address.
- i_imem_data  in  16  instruction word to write.
- o_pc  out  8  current PC.
- o_wb_en  out  1  register write occurs at the next edge; never asserted for rd=r0.
- o_wb_addr  out  3  destination register.
- o_wb_data  out  16  value being written.
- o_halt  out  1  core halted.

## Operation
- Instruction fields: op=[15:12], rd=[11:9], rs=[8:6], rt=[5:3], imm6=[5:0] sign-extended, imm9=[8:0] sign-extended, tgt=[7:0].
- r0 reads as 0; writes to r0 are discarded.
- 0 NOP.
- 1 ADD: rd=rs+rt. 2 SUB: rd=rs−rt. 3 AND. 4 OR. 5 XOR. All are 16-bit, and overflow wraps.
- 6 SLT: rd=(signed rs < signed rt)?1:0.
- 7 ADDI: rd=rs+imm6.
- 8 LI: rd=imm9.
- 9 LW: rd=dmem[(rs+imm6)[7:0]].
- A SW: dmem[(rs+imm6)[7:0]]=rd. No register write.
- B BEQ: if rd==rs then PC=PC+1+imm6.
- C BNE: if rd!=rs then PC=PC+1+imm6.
- D JMP: PC=tgt.
- E SHIFT: amount=imm6[3:0]. If imm6[4]=0, rd=rs<<amount; if imm6[4]=1, rd=rs>>amount (logical).
- F HALT: sets o_halt. PC freezes and no further writes occur until reset.
- PC arithmetic is 8-bit and wraps from 255 to 0.
- Data memory: asynchronous read, synchronous write. Its contents are not cleared by reset.
- Instruction memory: asynchronous read. It is writable only during reset, and its contents persist across reset.

## Timing
- Reset (i_rst_n=1 at an edge): PC=0, all registers=0, o_halt=0.
- Outputs during reset: o_wb_en=0, o_wb_addr=0, o_wb_data=0.
- Reset has priority over everything, including HALT and a write in flight.
- Reset mid-program aborts execution. The first edge after reset deassertion executes imem[0].
- Single-cycle execution: the instruction at o_pc is decoded combinationally.
- o_wb_en, o_wb_addr and o_wb_data are valid in the same cycle; the register file and PC update at the next rising edge.
- Register-file read-after-write: a write lands at the edge, so the next instruction sees the new value. No forwarding is required.
- SW and LW to the same address in consecutive instructions: the LW returns the stored value.
- A branch or jump redirects PC at the edge that ends the instruction; there are no delay slots.
- A branch to itself with its condition true loops forever.
- A taken branch whose target wraps past 255 or below 0 wraps modulo 256.

## Test plan
- Load imem {LI r1,5; LI r2,7; ADD r3,r1,r2; HALT}, then release reset:
  - wb sequence is (1,5), (2,7), (3,12).
  - o_halt=1 with o_pc=3 after 4 cycles.
  - o_pc stays at 3 for 10 more cycles.
- Arithmetic edges:
  - LI r1,−1; ADDI r2,r1,1 → r2=0x0000.
  - SUB r3,r0,r1 → 0x0001.
  - SLT r4,r1,r0 → 1.
  - SHIFT r5,r1 right 4 → 0x0FFF.
- Memory: LI r1,42; SW r1,[r0+3]; LW r2,[r0+3] → wb (2,42). Writes to r0 give o_wb_en=0.
- Control:
  - BNE loop decrementing r1 from 3 to 0 takes 3 passes, then falls through.
  - JMP 0x10 sets o_pc=0x10 next cycle.
  - BEQ with imm6=−1 at PC 0 wraps to 0 (o_pc=0).
- Reset mid-run: assert i_rst_n=1 for one edge while the program runs:
  - o_pc=0, registers cleared, o_halt=0.
  - The program reruns from imem[0] with identical wb sequence.

Source files
------------

// File: rtl/proc_top_level.sv
// rtl/proc_top_level.sv - single-cycle 16-bit proc_v3 core with local imem/dmem
module proc_top_level #(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_imem_we,
  input  logic [7:0]  i_imem_addr,
  input  logic [15:0] i_imem_data,
  output logic [7:0]  o_pc,
  output logic        o_wb_en,
  output logic [2:0]  o_wb_addr,
  output logic [15:0] o_wb_data,
  output logic        o_halt
);

  // Architectural state. i_rst_n is active-high despite its name.
  logic [7:0]  r_pc;
  logic        r_halt;
  logic [15:0] r_regs [0:7];
  logic [15:0] r_imem [0:IMEM_DEPTH-1];
  logic [15:0] r_dmem [0:DMEM_DEPTH-1];

  // Instruction fetch and field decode
  logic [15:0] w_instr;
  logic [3:0]  w_op;
  logic [2:0]  w_rd;
  logic [2:0]  w_rs;
  logic [2:0]  w_rt;
  logic [15:0] w_imm6;
  logic [15:0] w_imm9;
  logic [7:0]  w_imm6_lo;
  logic [7:0]  w_tgt;

  assign w_instr   = r_imem[r_pc];
  assign w_op      = w_instr[15:12];
  assign w_rd      = w_instr[11:9];
  assign w_rs      = w_instr[8:6];
  assign w_rt      = w_instr[5:3];
  assign w_imm6    = {{10{w_instr[5]}}, w_instr[5:0]};
  assign w_imm9    = {{7{w_instr[8]}}, w_instr[8:0]};
  assign w_imm6_lo = {{2{w_instr[5]}}, w_instr[5:0]};
  assign w_tgt     = w_instr[7:0];

  // Register reads; r0 is hardwired to zero on the read side
  logic [15:0] w_rs_val;
  logic [15:0] w_rt_val;
  logic [15:0] w_rd_val;

  assign w_rs_val = (w_rs == 3'd0) ? 16'd0 : r_regs[w_rs];
  assign w_rt_val = (w_rt == 3'd0) ? 16'd0 : r_regs[w_rt];
  assign w_rd_val = (w_rd == 3'd0) ? 16'd0 : r_regs[w_rd];

  // Address and branch arithmetic, all 8-bit so they wrap modulo 256
  logic [7:0] w_mem_addr;
  logic [7:0] w_pc_inc;
  logic [7:0] w_br_tgt;

  assign w_mem_addr = w_rs_val[7:0] + w_imm6_lo;
  assign w_pc_inc   = r_pc + 8'd1;
  assign w_br_tgt   = w_pc_inc + w_imm6_lo;

  logic        w_wb_req;
  logic [15:0] w_wb_val;
  logic [7:0]  w_next_pc;
  logic        w_dmem_we;
  logic        w_halt_now;
  logic        w_wr;

  // Execute: result, next PC and side effects of the current instruction
  always_comb begin
    w_wb_req   = 1'b0;
    w_wb_val   = 16'd0;
    w_next_pc  = w_pc_inc;
    w_dmem_we  = 1'b0;
    w_halt_now = 1'b0;
    case (w_op)
      4'h0: ;
      4'h1: begin w_wb_req = 1'b1; w_wb_val = w_rs_val + w_rt_val; end
      4'h2: begin w_wb_req = 1'b1; w_wb_val = w_rs_val - w_rt_val; end
      4'h3: begin w_wb_req = 1'b1; w_wb_val = w_rs_val & w_rt_val; end
      4'h4: begin w_wb_req = 1'b1; w_wb_val = w_rs_val | w_rt_val; end
      4'h5: begin w_wb_req = 1'b1; w_wb_val = w_rs_val ^ w_rt_val; end
      4'h6: begin
        w_wb_req = 1'b1;
        w_wb_val = {15'd0, ($signed(w_rs_val) < $signed(w_rt_val))};
      end
      4'h7: begin w_wb_req = 1'b1; w_wb_val = w_rs_val + w_imm6; end
      4'h8: begin w_wb_req = 1'b1; w_wb_val = w_imm9; end
      4'h9: begin w_wb_req = 1'b1; w_wb_val = r_dmem[w_mem_addr]; end
      4'hA: w_dmem_we = 1'b1;
      4'hB: if (w_rd_val == w_rs_val) w_next_pc = w_br_tgt;
      4'hC: if (w_rd_val != w_rs_val) w_next_pc = w_br_tgt;
      4'hD: w_next_pc = w_tgt;
      4'hE: begin
        w_wb_req = 1'b1;
        w_wb_val = w_instr[4] ? (w_rs_val >> w_instr[3:0]) : (w_rs_val << w_instr[3:0]);
      end
      4'hF: begin w_halt_now = 1'b1; w_next_pc = r_pc; end
    endcase
  end

  // A register write only happens when running, not in reset, and not to r0
  assign w_wr = w_wb_req && (w_rd != 3'd0) && !r_halt && !i_rst_n;

  assign o_pc      = r_pc;
  assign o_halt    = r_halt;
  assign o_wb_en   = w_wr;
  assign o_wb_addr = w_wr ? w_rd : 3'd0;
  assign o_wb_data = w_wr ? w_wb_val : 16'd0;

  // Core state: reset wins over halt and any in-flight write
  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      r_pc   <= 8'd0;
      r_halt <= 1'b0;
      for (int i = 0; i < 8; i++) r_regs[i] <= 16'd0;
    end else if (!r_halt) begin
      r_pc <= w_next_pc;
      if (w_halt_now) r_halt <= 1'b1;
      if (w_wr) r_regs[w_rd] <= w_wb_val;
    end
  end

  // Data memory write port; contents survive reset
  always_ff @(posedge i_clk) begin
    if (!i_rst_n && !r_halt && w_dmem_we) r_dmem[w_mem_addr] <= w_rd_val;
  end

  // Instruction memory load port, open only while reset is held
  always_ff @(posedge i_clk) begin
    if (i_rst_n && i_imem_we) r_imem[i_imem_addr] <= i_imem_data;
  end

endmodule

// File: tb/tb_proc_top_level.sv
// tb/tb_proc_top_level.sv - directed self-checking bench for proc_top_level
module tb_proc_top_level;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b1;
  logic        i_imem_we = 1'b0;
  logic [7:0]  i_imem_addr = 8'd0;
  logic [15:0] i_imem_data = 16'd0;
  logic [7:0]  o_pc;
  logic        o_wb_en;
  logic [2:0]  o_wb_addr;
  logic [15:0] o_wb_data;
  logic        o_halt;

  int n_checks = 0;
  int n_fail = 0;

  proc_top_level #(.IMEM_DEPTH(256), .DMEM_DEPTH(256)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_imem_we(i_imem_we), .i_imem_addr(i_imem_addr), .i_imem_data(i_imem_data),
    .o_pc(o_pc), .o_wb_en(o_wb_en), .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
    .o_halt(o_halt)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [2:0] rt);
    return {op, rd, rs, rt, 3'b000};
  endfunction

  function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs, input int imm);
    logic [31:0] v;
    v = imm;
    return {op, rd, rs, v[5:0]};
  endfunction

  function automatic logic [15:0] enc_li(input logic [2:0] rd, input int imm);
    logic [31:0] v;
    v = imm;
    return {4'h8, rd, v[8:0]};
  endfunction

  function automatic logic [15:0] enc_j(input logic [7:0] tgt);
    return {4'hD, 4'h0, tgt};
  endfunction

  localparam logic [15:0] HALT = 16'hF000;

  task automatic step;
    @(negedge i_clk);
    #1;
  endtask

  task automatic begin_load;
    i_rst_n = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic imem_write(input logic [7:0] a, input logic [15:0] d);
    i_imem_we = 1'b1;
    i_imem_addr = a;
    i_imem_data = d;
    @(negedge i_clk);
    i_imem_we = 1'b0;
  endtask

  task automatic release_reset;
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    i_rst_n = 1'b1;
    step;
    step;
    n_checks++;
    if (o_pc !== 8'd0) begin n_fail++; $display("FAIL reset_pc got %h want 00", o_pc); end
    n_checks++;
    if (o_halt !== 1'b0) begin n_fail++; $display("FAIL reset_halt got %b want 0", o_halt); end
    n_checks++;
    if ({o_wb_en, o_wb_addr, o_wb_data} !== 20'd0) begin
      n_fail++;
      $display("FAIL reset_wb got en=%b addr=%0d data=%h want 0/0/0000", o_wb_en, o_wb_addr, o_wb_data);
    end
  endtask

  task automatic test_basic;
    int e_addr[3] = '{1, 2, 3};
    int e_data[3] = '{5, 7, 12};
    begin_load;
    imem_write(8'd0, enc_li(3'd1, 5));
    imem_write(8'd1, enc_li(3'd2, 7));
    imem_write(8'd2, enc_r(4'h1, 3'd3, 3'd1, 3'd2));
    imem_write(8'd3, HALT);
    release_reset;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (o_pc !== 8'(i)) begin n_fail++; $display("FAIL basic_pc[%0d] got %h want %h", i, o_pc, 8'(i)); end
      n_checks++;
      if ({o_wb_en, o_wb_addr, o_wb_data} !== {1'b1, 3'(e_addr[i]), 16'(e_data[i])}) begin
        n_fail++;
        $display("FAIL basic_wb[%0d] got en=%b addr=%0d data=%h want 1/%0d/%h",
                 i, o_wb_en, o_wb_addr, o_wb_data, e_addr[i], 16'(e_data[i]));
      end
      step;
    end
    n_checks++;
    if (o_wb_en !== 1'b0 || o_halt !== 1'b0) begin
      n_fail++; $display("FAIL basic_haltcycle got en=%b halt=%b want 0/0", o_wb_en, o_halt);
    end
    step;
    n_checks++;
    if (o_halt !== 1'b1 || o_pc !== 8'd3) begin
      n_fail++; $display("FAIL basic_halted got halt=%b pc=%h want 1/03", o_halt, o_pc);
    end
    for (int i = 0; i < 10; i++) begin
      step;
      n_checks++;
      if (o_pc !== 8'd3 || o_halt !== 1'b1 || o_wb_en !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_frozen[%0d] got pc=%h halt=%b en=%b want 03/1/0", i, o_pc, o_halt, o_wb_en);
      end
    end
  endtask

  task automatic test_arith;
    int e_addr[7] = '{1, 2, 3, 4, 5, 6, 7};
    int e_data[7] = '{'hFFFF, 'h0000, 'h0001, 'h0001, 'h0FFF, 'hFFF0, 'hF000};
    begin_load;
    imem_write(8'd0, enc_li(3'd1, -1));
    imem_write(8'd1, enc_i(4'h7, 3'd2, 3'd1, 1));
    imem_write(8'd2, enc_r(4'h2, 3'd3, 3'd0, 3'd1));
    imem_write(8'd3, enc_r(4'h6, 3'd4, 3'd1, 3'd0));
    imem_write(8'd4, enc_i(4'hE, 3'd5, 3'd1, 'h14));
    imem_write(8'd5, enc_i(4'hE, 3'd6, 3'd1, 'h04));
    imem_write(8'd6, enc_r(4'h5, 3'd7, 3'd1, 3'd5));
    imem_write(8'd7, HALT);
    release_reset;
    for (int i = 0; i < 7; i++) begin
      n_checks++;
      if ({o_pc, o_wb_en, o_wb_addr, o_wb_data} !== {8'(i), 1'b1, 3'(e_addr[i]), 16'(e_data[i])}) begin
        n_fail++;
        $display("FAIL arith[%0d] got pc=%h en=%b addr=%0d data=%h want %h/1/%0d/%h",
                 i, o_pc, o_wb_en, o_wb_addr, o_wb_data, 8'(i), e_addr[i], 16'(e_data[i]));
      end
      step;
    end
  endtask

  task automatic test_memory;
    int e_en[5]   = '{1, 0, 1, 0, 1};
    int e_addr[5] = '{1, 0, 2, 0, 3};
    int e_data[5] = '{42, 0, 42, 0, 42};
    begin_load;
    imem_write(8'd0, enc_li(3'd1, 42));
    imem_write(8'd1, enc_i(4'hA, 3'd1, 3'd0, 3));
    imem_write(8'd2, enc_i(4'h9, 3'd2, 3'd0, 3));
    imem_write(8'd3, enc_li(3'd0, 9));
    imem_write(8'd4, enc_r(4'h1, 3'd3, 3'd0, 3'd2));
    imem_write(8'd5, HALT);
    release_reset;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (o_pc !== 8'(i) || o_wb_en !== 1'(e_en[i])) begin
        n_fail++;
        $display("FAIL mem_en[%0d] got pc=%h en=%b want %h/%0d", i, o_pc, o_wb_en, 8'(i), e_en[i]);
      end
      if (e_en[i] == 1) begin
        n_checks++;
        if ({o_wb_addr, o_wb_data} !== {3'(e_addr[i]), 16'(e_data[i])}) begin
          n_fail++;
          $display("FAIL mem_wb[%0d] got addr=%0d data=%h want %0d/%h",
                   i, o_wb_addr, o_wb_data, e_addr[i], 16'(e_data[i]));
        end
      end
      step;
    end
  endtask

  task automatic test_control;
    int e_pc[10]   = '{'h00, 'h01, 'h02, 'h01, 'h02, 'h01, 'h02, 'h03, 'h10, 'h11};
    int e_en[10]   = '{1, 1, 0, 1, 0, 1, 0, 0, 1, 0};
    int e_addr[10] = '{1, 1, 0, 1, 0, 1, 0, 0, 2, 0};
    int e_data[10] = '{3, 2, 0, 1, 0, 0, 0, 0, 5, 0};
    begin_load;
    imem_write(8'd0, enc_li(3'd1, 3));
    imem_write(8'd1, enc_i(4'h7, 3'd1, 3'd1, -1));
    imem_write(8'd2, enc_i(4'hC, 3'd1, 3'd0, -2));
    imem_write(8'd3, enc_j(8'h10));
    imem_write(8'h10, enc_li(3'd2, 5));
    imem_write(8'h11, HALT);
    release_reset;
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (o_pc !== 8'(e_pc[i]) || o_wb_en !== 1'(e_en[i])) begin
        n_fail++;
        $display("FAIL ctrl[%0d] got pc=%h en=%b want %h/%0d", i, o_pc, o_wb_en, 8'(e_pc[i]), e_en[i]);
      end
      if (e_en[i] == 1) begin
        n_checks++;
        if ({o_wb_addr, o_wb_data} !== {3'(e_addr[i]), 16'(e_data[i])}) begin
          n_fail++;
          $display("FAIL ctrl_wb[%0d] got addr=%0d data=%h want %0d/%h",
                   i, o_wb_addr, o_wb_data, e_addr[i], 16'(e_data[i]));
        end
      end
      step;
    end
    n_checks++;
    if (o_halt !== 1'b1 || o_pc !== 8'h11) begin
      n_fail++; $display("FAIL ctrl_halt got halt=%b pc=%h want 1/11", o_halt, o_pc);
    end
  endtask

  task automatic test_pc_wrap;
    int e_pc[6] = '{'h00, 'h01, 'hFE, 'h02, 'hFF, 'h00};
    begin_load;
    imem_write(8'd0, enc_li(3'd1, 1));
    imem_write(8'd1, enc_j(8'hFE));
    imem_write(8'hFE, enc_i(4'hC, 3'd1, 3'd0, 3));
    imem_write(8'd2, enc_j(8'hFF));
    imem_write(8'hFF, 16'h0000);
    release_reset;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (o_pc !== 8'(e_pc[i])) begin
        n_fail++; $display("FAIL wrap_pc[%0d] got %h want %h", i, o_pc, 8'(e_pc[i]));
      end
      step;
    end
    begin_load;
    imem_write(8'd0, enc_i(4'hB, 3'd0, 3'd0, -1));
    release_reset;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (o_pc !== 8'd0 || o_halt !== 1'b0 || o_wb_en !== 1'b0) begin
        n_fail++;
        $display("FAIL selfloop[%0d] got pc=%h halt=%b en=%b want 00/0/0", i, o_pc, o_halt, o_wb_en);
      end
      step;
    end
  endtask

  task automatic test_reset_mid_run;
    int e_addr[3] = '{4, 1, 2};
    int e_data[3] = '{0, 5, 7};
    begin_load;
    imem_write(8'd0, enc_r(4'h1, 3'd4, 3'd1, 3'd2));
    imem_write(8'd1, enc_li(3'd1, 5));
    imem_write(8'd2, enc_li(3'd2, 7));
    imem_write(8'd3, HALT);
    release_reset;
    step;
    i_rst_n = 1'b1;
    #1;
    n_checks++;
    if ({o_wb_en, o_wb_addr, o_wb_data} !== 20'd0) begin
      n_fail++;
      $display("FAIL midrst_wb got en=%b addr=%0d data=%h want 0/0/0000", o_wb_en, o_wb_addr, o_wb_data);
    end
    step;
    n_checks++;
    if (o_pc !== 8'd0 || o_halt !== 1'b0) begin
      n_fail++; $display("FAIL midrst_state got pc=%h halt=%b want 00/0", o_pc, o_halt);
    end
    i_rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({o_pc, o_wb_en, o_wb_addr, o_wb_data} !== {8'(i), 1'b1, 3'(e_addr[i]), 16'(e_data[i])}) begin
        n_fail++;
        $display("FAIL rerun[%0d] got pc=%h en=%b addr=%0d data=%h want %h/1/%0d/%h",
                 i, o_pc, o_wb_en, o_wb_addr, o_wb_data, 8'(i), e_addr[i], 16'(e_data[i]));
      end
      step;
    end
    step;
    n_checks++;
    if (o_halt !== 1'b1) begin n_fail++; $display("FAIL rerun_halt got %b want 1", o_halt); end
    i_rst_n = 1'b1;
    step;
    n_checks++;
    if (o_pc !== 8'd0 || o_halt !== 1'b0) begin
      n_fail++; $display("FAIL halt_rst got pc=%h halt=%b want 00/0", o_pc, o_halt);
    end
    i_rst_n = 1'b0;
    #1;
    n_checks++;
    if ({o_wb_en, o_wb_addr, o_wb_data} !== {1'b1, 3'd4, 16'd0}) begin
      n_fail++;
      $display("FAIL regs_cleared got en=%b addr=%0d data=%h want 1/4/0000", o_wb_en, o_wb_addr, o_wb_data);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_arith;
    test_memory;
    test_control;
    test_pc_wrap;
    test_reset_mid_run;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
